// File: rtl/draw_seq_pkg.sv
// Shared types for the drawing-engine sequencer.
// State encoding and channel-index width helper.
package draw_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } seq_state_t;

  function automatic int ach_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_sequencer_next_ch_sel.sv
// Channel picker: next enabled index above cur,
// plus the lowest enabled index of the mask.
module next_ch_sel
  import draw_seq_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int ACH_W = ach_w(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [ACH_W-1:0] cur,
  output logic [ACH_W-1:0] nxt,
  output logic             found,
  output logic [ACH_W-1:0] lowest
);

  // Scan downward so the last hit is the lowest.
  always_comb begin
    nxt    = '0;
    found  = 1'b0;
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (ACH_W'(i) > cur)) begin
        nxt   = ACH_W'(i);
        found = 1'b1;
      end
      if (mask[i]) begin
        lowest = ACH_W'(i);
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Runs drawing engines one after another and
// muxes the owning engine's pixels onto the VGA port.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int C_W  = 3,
  localparam int ACH_W = ach_w(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                loop_mode,
  input  logic [N_CH-1:0]     eng_done,
  input  logic [N_CH*X_W-1:0] eng_x,
  input  logic [N_CH*Y_W-1:0] eng_y,
  input  logic [N_CH*C_W-1:0] eng_colour,
  input  logic [N_CH-1:0]     eng_plot,
  output logic [N_CH-1:0]     eng_start,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [C_W-1:0]      vga_colour,
  output logic                vga_plot,
  output logic [ACH_W-1:0]    active_ch,
  output logic                busy,
  output logic                done
);

  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  seq_state_t       state_q, state_d;
  logic [N_CH-1:0]  en_q, en_d;
  logic [ACH_W-1:0] act_q, act_d;
  logic [N_CH-1:0]  est_q, est_d;

  logic [N_CH-1:0]  sel_mask;
  logic [ACH_W-1:0] sel_nxt;
  logic             sel_found;
  logic [ACH_W-1:0] sel_low;

  // In IDLE the incoming mask is the one being latched.
  assign sel_mask = (state_q == S_IDLE) ? ch_en : en_q;

  next_ch_sel #(
    .N_CH  (N_CH),
    .ACH_W (ACH_W)
  ) u_sel (
    .mask   (sel_mask),
    .cur    (act_q),
    .nxt    (sel_nxt),
    .found  (sel_found),
    .lowest (sel_low)
  );

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    act_d   = act_q;
    est_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d = ch_en;
          if (ch_en == '0) begin
            state_d = S_DONE;
          end else begin
            act_d   = sel_low;
            state_d = S_RUN;
            est_d   = ONE << sel_low;
          end
        end
      end
      S_RUN: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (eng_done[act_q]) begin
          state_d = S_GAP;
        end else begin
          est_d = ONE << act_q;
        end
      end
      S_GAP: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (!eng_done[act_q]) begin
          if (sel_found) begin
            act_d   = sel_nxt;
            state_d = S_RUN;
            est_d   = ONE << sel_nxt;
          end else if (loop_mode) begin
            act_d   = sel_low;
            state_d = S_RUN;
            est_d   = ONE << sel_low;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      act_q   <= '0;
      est_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      act_q   <= act_d;
      est_q   <= est_d;
    end
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ACH_W'(i) == act_q) begin
        vga_x      = eng_x[i*X_W +: X_W];
        vga_y      = eng_y[i*Y_W +: Y_W];
        vga_colour = eng_colour[i*C_W +: C_W];
      end
    end
  end

  assign vga_plot  = eng_plot[act_q] & (state_q == S_RUN);
  assign eng_start = est_q;
  assign active_ch = act_q;
  assign busy      = (state_q == S_RUN) | (state_q == S_GAP);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: vector table, async reset
// sequence, and randomized runs against an order model.
module tb_draw_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  ch_en;
  logic        loop_mode;
  logic [3:0]  eng_done;
  logic [31:0] eng_x;
  logic [27:0] eng_y;
  logic [11:0] eng_colour;
  logic [3:0]  eng_plot;
  logic [3:0]  eng_start;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [1:0]  active_ch;
  logic        busy;
  logic        done;

  draw_sequencer #(
    .N_CH (4),
    .X_W  (8),
    .Y_W  (7),
    .C_W  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ch_en      (ch_en),
    .loop_mode  (loop_mode),
    .eng_done   (eng_done),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_colour (eng_colour),
    .eng_plot   (eng_plot),
    .eng_start  (eng_start),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .active_ch  (active_ch),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  typedef struct {
    logic       st;
    logic [3:0] en;
    logic       lp;
    logic [3:0] dn;
    logic [3:0] es;
    logic [1:0] act;
    logic       b;
    logic       d;
    logic       p;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic [3:0] en,
                     input logic lp, input logic [3:0] dn,
                     input logic [3:0] es, input logic [1:0] act,
                     input logic b, input logic d,
                     input logic p);
    vec_t v;
    v = '{st, en, lp, dn, es, act, b, d, p};
    vq.push_back(v);
  endtask

  // Randomized-run model state
  int expq[$];
  int cur, starts, passes, k;
  int cnt[4], lat[4], hold[4];
  logic [3:0] prev_es;

  task automatic step();
    logic [3:0] es;
    es = eng_start;
    chk("plot_gate", 32'(vga_plot), 32'(|(es & eng_plot)));
    if (es != 4'b0) begin
      if (prev_es == 4'b0) begin
        chk("onehot", 32'($onehot(es)), 32'd1);
        if (expq.size() == 0) begin
          chk("extra_start", 32'(es), 32'd0);
        end else begin
          cur = expq.pop_front();
          chk("start_ch", 32'(es), 32'(4'b0001 << cur));
          starts++;
        end
      end
      chk("mux_x", 32'(vga_x), 32'(eng_x[cur*8 +: 8]));
      chk("mux_c", 32'(vga_colour),
          32'(eng_colour[cur*3 +: 3]));
    end
    prev_es = es;
    for (int i = 0; i < 4; i++) begin
      if (es[i]) begin
        cnt[i]++;
        if (cnt[i] >= lat[i] && !eng_done[i]) begin
          eng_done[i] = 1'b1;
          hold[i] = $urandom_range(0, 2);
        end
      end else begin
        cnt[i] = 0;
        if (eng_done[i]) begin
          if (hold[i] == 0) eng_done[i] = 1'b0;
          else hold[i]--;
        end
      end
    end
    eng_plot   = 4'($urandom);
    eng_x      = $urandom;
    eng_y      = 28'($urandom);
    eng_colour = 12'($urandom);
    loop_mode  = (starts < passes * k);
  endtask

  initial begin
    vec_t v;
    logic [3:0] m;
    bit abort, got_done;
    int abort_at;

    rst_n = 1'b0;
    start = 1'b0;
    ch_en = 4'b0;
    loop_mode = 1'b0;
    eng_done = 4'b0;
    eng_plot = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      eng_x[i*8 +: 8]      = 8'(8'h10 + i);
      eng_y[i*7 +: 7]      = 7'(7'h20 + i);
      eng_colour[i*3 +: 3] = 3'(i + 1);
    end

    #12;
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_act", 32'(active_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_x", 32'(vga_x), 32'h10);
    @(negedge clk);
    rst_n = 1'b1;

    add(1'b0,4'b1010,1'b0,4'b0000,4'b0000,2'd0,1'b0,1'b0,1'b0);
    add(1'b1,4'b1010,1'b0,4'b0000,4'b0010,2'd1,1'b1,1'b0,1'b1);
    add(1'b1,4'b0000,1'b0,4'b0000,4'b0010,2'd1,1'b1,1'b0,1'b1);
    add(1'b1,4'b0000,1'b0,4'b1000,4'b0010,2'd1,1'b1,1'b0,1'b1);
    add(1'b1,4'b0000,1'b0,4'b0010,4'b0000,2'd1,1'b1,1'b0,1'b0);
    add(1'b1,4'b0000,1'b0,4'b0010,4'b0000,2'd1,1'b1,1'b0,1'b0);
    add(1'b1,4'b0000,1'b0,4'b0000,4'b1000,2'd3,1'b1,1'b0,1'b1);
    add(1'b1,4'b0000,1'b0,4'b1000,4'b0000,2'd3,1'b1,1'b0,1'b0);
    add(1'b1,4'b0000,1'b0,4'b0000,4'b0000,2'd3,1'b0,1'b1,1'b0);
    add(1'b1,4'b0000,1'b0,4'b0000,4'b0000,2'd3,1'b0,1'b1,1'b0);
    add(1'b0,4'b0000,1'b0,4'b0000,4'b0000,2'd3,1'b0,1'b0,1'b0);
    add(1'b1,4'b0000,1'b0,4'b0000,4'b0000,2'd3,1'b0,1'b1,1'b0);
    add(1'b0,4'b0000,1'b0,4'b0000,4'b0000,2'd3,1'b0,1'b0,1'b0);
    add(1'b1,4'b0001,1'b1,4'b0000,4'b0001,2'd0,1'b1,1'b0,1'b1);
    add(1'b1,4'b0001,1'b1,4'b0001,4'b0000,2'd0,1'b1,1'b0,1'b0);
    add(1'b1,4'b0001,1'b1,4'b0000,4'b0001,2'd0,1'b1,1'b0,1'b1);
    add(1'b1,4'b0001,1'b1,4'b0001,4'b0000,2'd0,1'b1,1'b0,1'b0);
    add(1'b1,4'b0001,1'b0,4'b0000,4'b0000,2'd0,1'b0,1'b1,1'b0);
    add(1'b0,4'b0001,1'b0,4'b0000,4'b0000,2'd0,1'b0,1'b0,1'b0);
    add(1'b1,4'b0100,1'b0,4'b0000,4'b0100,2'd2,1'b1,1'b0,1'b1);
    add(1'b0,4'b0100,1'b0,4'b0100,4'b0000,2'd2,1'b0,1'b0,1'b0);
    add(1'b1,4'b0100,1'b0,4'b0000,4'b0100,2'd2,1'b1,1'b0,1'b1);
    add(1'b1,4'b0100,1'b0,4'b0100,4'b0000,2'd2,1'b1,1'b0,1'b0);
    add(1'b0,4'b0100,1'b0,4'b0100,4'b0000,2'd2,1'b0,1'b0,1'b0);
    add(1'b0,4'b0100,1'b0,4'b0000,4'b0000,2'd2,1'b0,1'b0,1'b0);
    add(1'b1,4'b0110,1'b1,4'b0000,4'b0010,2'd1,1'b1,1'b0,1'b1);
    add(1'b1,4'b0110,1'b1,4'b0010,4'b0000,2'd1,1'b1,1'b0,1'b0);
    add(1'b1,4'b0110,1'b1,4'b0000,4'b0100,2'd2,1'b1,1'b0,1'b1);
    add(1'b1,4'b0110,1'b1,4'b0100,4'b0000,2'd2,1'b1,1'b0,1'b0);
    add(1'b1,4'b0110,1'b1,4'b0000,4'b0010,2'd1,1'b1,1'b0,1'b1);
    add(1'b0,4'b0110,1'b1,4'b0000,4'b0000,2'd1,1'b0,1'b0,1'b0);

    foreach (vq[i]) begin
      v = vq[i];
      @(negedge clk);
      start = v.st;
      ch_en = v.en;
      loop_mode = v.lp;
      eng_done = v.dn;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_start", i), 32'(eng_start), 32'(v.es));
      chk($sformatf("v%0d_act", i), 32'(active_ch), 32'(v.act));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v.b));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(v.d));
      chk($sformatf("v%0d_plot", i), 32'(vga_plot), 32'(v.p));
      chk($sformatf("v%0d_x", i), 32'(vga_x),
          32'(8'h10) + 32'(v.act));
    end

    // Async reset pulsed between edges while channel 1 runs
    @(negedge clk);
    start = 1'b1;
    ch_en = 4'b0010;
    loop_mode = 1'b0;
    eng_done = 4'b0;
    eng_plot = 4'b1111;
    @(posedge clk);
    #1;
    chk("ar_run", 32'(eng_start), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_start", 32'(eng_start), 32'd0);
    chk("ar_plot", 32'(vga_plot), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_act", 32'(active_ch), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("ar_plot2", 32'(vga_plot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_idle", 32'(busy), 32'd0);
    chk("ar_plot3", 32'(vga_plot), 32'd0);

    // Randomized sequences against the channel-order model
    prev_es = 4'b0;
    cur = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      hold[i] = 0;
      lat[i] = 1;
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      m = ($urandom_range(0, 4) == 0) ? 4'b0 :
          4'($urandom_range(1, 15));
      passes = $urandom_range(1, 3);
      abort = ($urandom_range(0, 3) == 0);
      abort_at = $urandom_range(2, 30);
      expq.delete();
      k = 0;
      for (int i = 0; i < 4; i++) if (m[i]) k++;
      for (int p = 0; p < passes; p++)
        for (int i = 0; i < 4; i++)
          if (m[i]) expq.push_back(i);
      for (int i = 0; i < 4; i++) lat[i] = $urandom_range(1, 6);
      starts = 0;
      loop_mode = (starts < passes * k);
      ch_en = m;
      start = 1'b1;
      got_done = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        step();
        ch_en = 4'($urandom);
        if (done) begin
          got_done = 1'b1;
          break;
        end
        if (abort && c == abort_at) break;
      end
      if (got_done) begin
        chk("rnd_left", 32'(expq.size()), 32'd0);
        chk("rnd_busy", 32'(busy), 32'd0);
        chk("rnd_es", 32'(eng_start), 32'd0);
      end else if (abort) begin
        start = 1'b0;
        @(negedge clk);
        step();
        chk("ab_es", 32'(eng_start), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
      end else begin
        chk("rnd_timeout", 32'd1, 32'(done));
      end
      start = 1'b0;
      expq.delete();
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        step();
      end
      chk("rnd_idle", 32'(busy | done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
